// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures the period of a slow asynchronous clock in
// clk_100MHz cycles, flags lock when the period stays within tolerance of
// the expected value, and pulses timeout when the input stalls.
module clk_period_monitor #(
  parameter int unsigned EXPECTED   = 100002,
  parameter int unsigned TOLERANCE  = 16,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 200000,
  parameter int unsigned CNT_W      = 18
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             clk_in,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned DIFF_W = CNT_W + 1;
  localparam int unsigned LOCK_W = 4;

  typedef enum logic {
    WAIT_FIRST,
    MEASURE
  } state_t;

  state_t            state;
  logic              s1;
  logic              s2;
  logic              s3;
  logic [CNT_W-1:0]  cnt;
  logic [LOCK_W-1:0] lock_cnt;

  logic              rise_c;
  logic [DIFF_W-1:0] cnt_ext_c;
  logic [DIFF_W-1:0] diff_c;
  logic              match_c;
  logic [LOCK_W-1:0] lock_next_c;

  // Edge detect and match test; one extra bit so the subtraction never wraps
  always_comb begin
    rise_c      = s2 & ~s3;
    cnt_ext_c   = {1'b0, cnt};
    diff_c      = (cnt_ext_c >= DIFF_W'(EXPECTED)) ? (cnt_ext_c - DIFF_W'(EXPECTED))
                                                   : (DIFF_W'(EXPECTED) - cnt_ext_c);
    match_c     = (diff_c <= DIFF_W'(TOLERANCE));
    lock_next_c = (lock_cnt >= LOCK_W'(LOCK_COUNT)) ? lock_cnt : (lock_cnt + LOCK_W'(1));
  end

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Measurement FSM: period counting, lock tracking and stall detection
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_FIRST;
      cnt          <= '0;
      lock_cnt     <= '0;
      period       <= '0;
      edge_tick    <= 1'b0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      edge_tick    <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          if (rise_c) begin
            edge_tick <= 1'b1;
            cnt       <= CNT_W'(1);
            state     <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise_c) begin
            edge_tick    <= 1'b1;
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= CNT_W'(1);
            if (match_c) begin
              lock_cnt <= lock_next_c;
              locked   <= (lock_next_c == LOCK_W'(LOCK_COUNT));
            end else begin
              lock_cnt <= '0;
              locked   <= 1'b0;
            end
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            // Stall: drop lock and wait for a fresh reference edge
            timeout  <= 1'b1;
            locked   <= 1'b0;
            lock_cnt <= '0;
            cnt      <= '0;
            state    <= WAIT_FIRST;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= WAIT_FIRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Testbench for clk_period_monitor with scaled-down parameters; a cycle-level
// event model derives expected ticks, periods, lock and timeouts from the
// sampled input waveform.
module tb_clk_period_monitor;

  localparam int unsigned E   = 40;
  localparam int unsigned TOL = 3;
  localparam int unsigned LC  = 4;
  localparam int unsigned TO  = 100;
  localparam int unsigned CW  = 8;

  logic          clk_100MHz = 1'b0;
  logic          reset_n    = 1'b0;
  logic          clk_in     = 1'b0;
  logic          edge_tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          timeout;

  clk_period_monitor #(
    .EXPECTED  (E),
    .TOLERANCE (TOL),
    .LOCK_COUNT(LC),
    .TIMEOUT   (TO),
    .CNT_W     (CW)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .clk_in      (clk_in),
    .edge_tick   (edge_tick),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: input samples taken at each clock edge; a rise seen in
  // the sample stream is reported two edges later.
  int       cyc = 0;
  bit [2:0] hist;
  bit       tick;
  bit       m_ref;
  int       m_last;
  int       m_period;
  int       m_run;
  bit       m_locked;
  bit       e_tick;
  bit       e_pv;
  bit       e_to;
  int       p;
  int       d;

  always @(posedge clk_100MHz) begin
    cyc++;
    if (!reset_n) begin
      hist     = '0;
      m_ref    = 1'b0;
      m_period = 0;
      m_run    = 0;
      m_locked = 1'b0;
      e_tick   = 1'b0;
      e_pv     = 1'b0;
      e_to     = 1'b0;
    end else begin
      tick   = hist[1] & ~hist[2];
      hist   = {hist[1:0], clk_in};
      e_tick = tick;
      e_pv   = 1'b0;
      e_to   = 1'b0;
      if (tick) begin
        if (m_ref) begin
          p        = cyc - m_last;
          m_period = p;
          e_pv     = 1'b1;
          d        = (p > int'(E)) ? p - int'(E) : int'(E) - p;
          if (d <= int'(TOL)) begin
            m_run    = (m_run + 1 > int'(LC)) ? int'(LC) : m_run + 1;
            m_locked = (m_run == int'(LC));
          end else begin
            m_run    = 0;
            m_locked = 1'b0;
          end
        end
        m_ref  = 1'b1;
        m_last = cyc;
      end else if (m_ref && (cyc - m_last == int'(TO))) begin
        e_to     = 1'b1;
        m_locked = 1'b0;
        m_run    = 0;
        m_ref    = 1'b0;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk_100MHz) begin
    if (chk_on) begin
      check("edge_tick", edge_tick, e_tick);
      check("period_valid", period_valid, e_pv);
      check("timeout", timeout, e_to);
      check("period", period, m_period);
      check("locked", locked, m_locked);
    end
  end

  task automatic run_level(input bit v, input int len);
    clk_in = v;
    repeat (len) begin
      @(negedge clk_100MHz);
      #1;
    end
  endtask

  task automatic per(input int hi, input int lo);
    run_level(1'b1, hi);
    run_level(1'b0, lo);
  endtask

  int rp;
  int rh;

  initial begin
    reset_n = 1'b0;
    clk_in  = 1'b0;
    repeat (3) begin
      @(negedge clk_100MHz);
      #1;
    end
    chk_on = 1'b1;

    // Input running while held in reset
    repeat (2) per(20, 20);
    reset_n = 1'b1;
    run_level(1'b0, 5);

    // Nominal input: lock on the fourth matching period
    repeat (6) per(20, 20);

    // Tolerance edges: 43 and 37 match, 44 breaks lock, then relock
    per(22, 21);
    per(19, 18);
    per(22, 22);
    repeat (5) per(20, 20);

    // Period equal to TIMEOUT (rise wins), then one cycle longer (stall)
    per(50, 50);
    per(50, 51);
    repeat (2) per(20, 20);

    // Randomized periods around and far from nominal
    repeat (40) begin
      rp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 120))
                                       : int'(E) - 5 + int'($urandom_range(0, 10));
      rh = int'($urandom_range(2, rp - 2));
      per(rh, rp - rh);
    end

    // Stall after lock
    repeat (6) per(20, 20);
    run_level(1'b1, 20);
    run_level(1'b0, 130);
    repeat (2) per(20, 20);

    // Reset mid-period while locked
    repeat (6) per(20, 20);
    run_level(1'b1, 5);
    reset_n = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_period", period, 0);
    check("rst_cnt", dut.cnt, 0);
    check("rst_edge_tick", edge_tick, 0);
    repeat (3) begin
      @(negedge clk_100MHz);
      #1;
    end
    reset_n = 1'b1;
    check("rst_state", int'(dut.state), 0);
    run_level(1'b1, 15);
    run_level(1'b0, 20);
    repeat (3) per(20, 20);

    // Fast input: period 4, never locks
    repeat (20) per(2, 2);
    run_level(1'b0, 10);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
